vga_scan_out: RTL and testbench

Display-side end of the pixel interface used by the game top level. It free-runs the 640×480@60 Hz raster on `vgaclk` and presents `row`/`column` scan coordinates to the renderer. It samples the renderer's 8-bit `color` after a fixed pipeline latency and drives blanked RGB332 plus sync pins, delayed so that sync and pixel data stay aligned. It replaces the counter/output half of the VGA path; clock division stays outside this block.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_scan_out_sync_delay.sv | 29 ++
 rtl/vga_scan_out.sv | 147 ++++++++++++++
 tb/tb_vga_scan_out.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Raster timing helpers and pixel/control field types shared by the VGA scan-out path.
// Totals and sync windows are derived from the per-instance porch/pulse parameters.
package vga_timing_pkg;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb332_t;

  // Bundle carried through the renderer-latency delay line.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } scan_ctl_t;

  localparam int unsigned SCAN_CTL_W = $bits(scan_ctl_t);

  function automatic int unsigned scan_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sync_w, input int unsigned bp);
    return vis + fp + sync_w + bp;
  endfunction

  function automatic int unsigned sync_first(input int unsigned vis, input int unsigned fp);
    return vis + fp;
  endfunction

  function automatic int unsigned sync_last(input int unsigned vis, input int unsigned fp,
                                            input int unsigned sync_w);
    return vis + fp + sync_w - 1;
  endfunction

  function automatic rgb332_t rgb332_fields(input logic [7:0] color);
    return rgb332_t'(color);
  endfunction

endpackage

// File: rtl/vga_scan_out_sync_delay.sv
// Fixed-depth shift register that realigns control bits with the renderer's pixel latency.
// Every stage loads the supplied reset pattern so no stale sync level survives a reset.
module sync_delay #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 1
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // NOTE: every stage is reset (not just the head) so a mid-frame reset cannot leave a partial sync pulse in flight.
  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= i_rst_val;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's old value, giving a true shift.
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_out.sv
// Free-running VGA raster: scan coordinates to the renderer, latency-matched RGB332 and sync pins.
// Coordinate outputs are registered from next-count values so they track the counters with no lag.
module vga_scan_out
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned LAT      = 1
) (
  input  logic       vgaclk,
  input  logic       rst,
  output logic [8:0] row,
  output logic [9:0] column,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  input  logic [7:0] color,
  output logic [2:0] vgaRed,
  output logic [2:0] vgaGreen,
  output logic [1:0] vgaBlue,
  output logic       vgaHsync,
  output logic       vgaVsync
);

  localparam int unsigned H_TOTAL  = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_FIRST = sync_first(H_ACTIVE, H_FP);
  localparam int unsigned HS_LAST  = sync_last(H_ACTIVE, H_FP, H_SYNC);
  localparam int unsigned VS_FIRST = sync_first(V_ACTIVE, V_FP);
  localparam int unsigned VS_LAST  = sync_last(V_ACTIVE, V_FP, V_SYNC);

  logic [9:0] r_hcount;
  logic [9:0] r_vcount;
  logic [8:0] r_row;
  logic       r_active;
  logic       r_line_start;
  logic       r_frame_start;
  logic [7:0] r_rgb;
  logic       r_hsync;
  logic       r_vsync;

  logic [9:0] w_hcount_nxt;
  logic [9:0] w_vcount_nxt;
  logic [8:0] w_row_nxt;
  logic       w_active_nxt;
  logic       w_line_start_nxt;
  logic       w_frame_start_nxt;
  logic       w_raw_hsync;
  logic       w_raw_vsync;
  scan_ctl_t  w_ctl_in;
  scan_ctl_t  w_ctl_rst;
  scan_ctl_t  w_ctl_dly;
  rgb332_t    w_pix;

  // Explicit wrap compares: the totals are not powers of two.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    w_hcount_nxt = r_hcount + 10'd1;
    w_vcount_nxt = r_vcount;
    if (r_hcount == 10'(H_TOTAL - 1)) begin
      w_hcount_nxt = '0;
      if (r_vcount == 10'(V_TOTAL - 1)) w_vcount_nxt = '0;
      else                              w_vcount_nxt = r_vcount + 10'd1;
    end
  end

  always_comb begin
    w_active_nxt      = (w_hcount_nxt < 10'(H_ACTIVE)) && (w_vcount_nxt < 10'(V_ACTIVE));
    w_row_nxt         = '0;
    if (w_vcount_nxt < 10'(V_ACTIVE)) w_row_nxt = w_vcount_nxt[8:0];
    w_line_start_nxt  = (w_hcount_nxt == '0);
    w_frame_start_nxt = (w_hcount_nxt == '0) && (w_vcount_nxt == '0);
  end

  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_row         <= '0;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_row         <= w_row_nxt;
      r_active      <= w_active_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  // Raw syncs are decoded from the counters currently on show, already at pin polarity.
  always_comb begin
    w_raw_hsync = ~SYNC_POL;
    w_raw_vsync = ~SYNC_POL;
    if ((r_hcount >= 10'(HS_FIRST)) && (r_hcount <= 10'(HS_LAST))) w_raw_hsync = SYNC_POL;
    if ((r_vcount >= 10'(VS_FIRST)) && (r_vcount <= 10'(VS_LAST))) w_raw_vsync = SYNC_POL;
  end

  assign w_ctl_in  = '{active: r_active, hsync: w_raw_hsync, vsync: w_raw_vsync};
  assign w_ctl_rst = '{active: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL};

  sync_delay #(
    .WIDTH (SCAN_CTL_W),
    .DEPTH (LAT)
  ) u_sync_delay (
    .vgaclk    (vgaclk),
    .rst       (rst),
    .i_rst_val (w_ctl_rst),
    .i_d       (w_ctl_in),
    .o_q       (w_ctl_dly)
  );

  // Pixel and sync pins share one register stage so they reach the connector together.
  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      r_rgb   <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else begin
      r_rgb   <= w_ctl_dly.active ? color : 8'h00;
      r_hsync <= w_ctl_dly.hsync;
      r_vsync <= w_ctl_dly.vsync;
    end
  end

  assign w_pix       = rgb332_fields(r_rgb);
  assign row         = r_row;
  assign column      = r_hcount;
  assign active      = r_active;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign vgaRed      = w_pix.red;
  assign vgaGreen    = w_pix.green;
  assign vgaBlue     = w_pix.blue;
  assign vgaHsync    = r_hsync;
  assign vgaVsync    = r_vsync;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: one full-size instance plus two shrunken rasters (LAT 1 and 3),
// all checked each cycle against an arithmetic raster model driven from a shared cycle index.
module tb_vga_scan_out;

  localparam int N = 3;

  int ha  [N] = '{640, 40, 40};
  int hfp [N] = '{16, 4, 4};
  int hsw [N] = '{96, 8, 8};
  int hbp [N] = '{48, 6, 6};
  int va  [N] = '{480, 12, 12};
  int vfp [N] = '{10, 3, 3};
  int vsw [N] = '{2, 2, 2};
  int vbp [N] = '{33, 4, 4};
  int lat [N] = '{1, 1, 3};

  logic       vgaclk = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] color_i [N];
  logic [8:0] row_o   [N];
  logic [9:0] col_o   [N];
  logic       act_o   [N];
  logic       ls_o    [N];
  logic       fs_o    [N];
  logic [2:0] red_o   [N];
  logic [2:0] grn_o   [N];
  logic [1:0] blu_o   [N];
  logic       hs_o    [N];
  logic       vs_o    [N];

  always #20 vgaclk = ~vgaclk;

  vga_scan_out #(.LAT(1)) u_dut0 (
    .vgaclk(vgaclk), .rst(rst), .row(row_o[0]), .column(col_o[0]), .active(act_o[0]),
    .line_start(ls_o[0]), .frame_start(fs_o[0]), .color(color_i[0]), .vgaRed(red_o[0]),
    .vgaGreen(grn_o[0]), .vgaBlue(blu_o[0]), .vgaHsync(hs_o[0]), .vgaVsync(vs_o[0]));

  vga_scan_out #(.H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6), .V_ACTIVE(12), .V_FP(3),
                 .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0), .LAT(1)) u_dut1 (
    .vgaclk(vgaclk), .rst(rst), .row(row_o[1]), .column(col_o[1]), .active(act_o[1]),
    .line_start(ls_o[1]), .frame_start(fs_o[1]), .color(color_i[1]), .vgaRed(red_o[1]),
    .vgaGreen(grn_o[1]), .vgaBlue(blu_o[1]), .vgaHsync(hs_o[1]), .vgaVsync(vs_o[1]));

  vga_scan_out #(.H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6), .V_ACTIVE(12), .V_FP(3),
                 .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0), .LAT(3)) u_dut2 (
    .vgaclk(vgaclk), .rst(rst), .row(row_o[2]), .column(col_o[2]), .active(act_o[2]),
    .line_start(ls_o[2]), .frame_start(fs_o[2]), .color(color_i[2]), .vgaRed(red_o[2]),
    .vgaGreen(grn_o[2]), .vgaBlue(blu_o[2]), .vgaHsync(hs_o[2]), .vgaVsync(vs_o[2]));

  int    tests = 0;
  int    fails = 0;
  int    k;            // cycles since the reset-release cycle (release cycle is 0)
  int    mode;         // 0: constant A5, 1: column byte, 2: random
  logic [7:0] colhist [N][16];
  int    mism;
  string first_msg;
  int    hs_fall [N][8], hs_rise [N][8], vs_fall [N][8], vs_rise [N][8], fs_k [N][8];
  int    hs_nf [N], hs_nr [N], vs_nf [N], vs_nr [N], fs_n [N];
  logic  prev_hs [N], prev_vs [N];
  int    vb_cycles, vb_bad, vb_colmax;

  function automatic int htot(int i); return ha[i] + hfp[i] + hsw[i] + hbp[i]; endfunction
  function automatic int vtot(int i); return va[i] + vfp[i] + vsw[i] + vbp[i]; endfunction
  function automatic int hc(int i, int kk); return kk % htot(i); endfunction
  function automatic int vc(int i, int kk); return (kk / htot(i)) % vtot(i); endfunction
  function automatic bit act_at(int i, int kk);
    return (kk > 0) && (hc(i, kk) < ha[i]) && (vc(i, kk) < va[i]);
  endfunction
  function automatic bit in_hs(int i, int kk);
    return (kk >= 0) && (hc(i, kk) >= ha[i] + hfp[i]) && (hc(i, kk) < ha[i] + hfp[i] + hsw[i]);
  endfunction
  function automatic bit in_vs(int i, int kk);
    return (kk >= 0) && (vc(i, kk) >= va[i] + vfp[i]) && (vc(i, kk) < va[i] + vfp[i] + vsw[i]);
  endfunction

  task automatic drive_colors();
    for (int i = 0; i < N; i++) begin
      int m;
      logic [7:0] c;
      m = k - lat[i];
      case (mode)
        0:       c = 8'hA5;
        1:       c = (m >= 0) ? 8'(hc(i, m)) : 8'h00;
        default: c = 8'($urandom);
      endcase
      colhist[i][k % 16] = c;
      color_i[i] = c;
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < N; i++) begin
      int h, v, j;
      logic [9:0] e_col;
      logic [8:0] e_row;
      logic e_act, e_ls, e_fs, e_hs, e_vs;
      logic [7:0] e_rgb, got_rgb;
      h = hc(i, k);
      v = vc(i, k);
      j = k - lat[i] - 1;
      e_col = 10'(h);
      e_row = (v < va[i]) ? 9'(v) : 9'd0;
      e_act = act_at(i, k);
      e_ls  = (k > 0) && (h == 0);
      e_fs  = e_ls && (v == 0);
      e_hs  = in_hs(i, j) ? 1'b0 : 1'b1;
      e_vs  = in_vs(i, j) ? 1'b0 : 1'b1;
      e_rgb = (j >= 0 && act_at(i, j)) ? colhist[i][(k - 1) % 16] : 8'h00;
      got_rgb = {red_o[i], grn_o[i], blu_o[i]};
      if (col_o[i] !== e_col || row_o[i] !== e_row || act_o[i] !== e_act || ls_o[i] !== e_ls ||
          fs_o[i] !== e_fs || got_rgb !== e_rgb || hs_o[i] !== e_hs || vs_o[i] !== e_vs) begin
        if (mism == 0)
          first_msg = $sformatf("inst%0d k=%0d col %0d/%0d row %0d/%0d act %b/%b ls %b/%b fs %b/%b rgb %h/%h hs %b/%b vs %b/%b",
                                i, k, col_o[i], e_col, row_o[i], e_row, act_o[i], e_act, ls_o[i], e_ls,
                                fs_o[i], e_fs, got_rgb, e_rgb, hs_o[i], e_hs, vs_o[i], e_vs);
        mism++;
      end
      if (i > 0 && v >= va[i]) begin
        vb_cycles++;
        if (row_o[i] !== 9'd0 || act_o[i] !== 1'b0) vb_bad++;
        if (int'(col_o[i]) > vb_colmax) vb_colmax = int'(col_o[i]);
      end
    end
  endtask

  task automatic log_events();
    for (int i = 0; i < N; i++) begin
      if (prev_hs[i] === 1'b1 && hs_o[i] === 1'b0 && hs_nf[i] < 8) begin hs_fall[i][hs_nf[i]] = k; hs_nf[i]++; end
      if (prev_hs[i] === 1'b0 && hs_o[i] === 1'b1 && hs_nr[i] < 8) begin hs_rise[i][hs_nr[i]] = k; hs_nr[i]++; end
      if (prev_vs[i] === 1'b1 && vs_o[i] === 1'b0 && vs_nf[i] < 8) begin vs_fall[i][vs_nf[i]] = k; vs_nf[i]++; end
      if (prev_vs[i] === 1'b0 && vs_o[i] === 1'b1 && vs_nr[i] < 8) begin vs_rise[i][vs_nr[i]] = k; vs_nr[i]++; end
      if (fs_o[i] === 1'b1 && fs_n[i] < 8) begin fs_k[i][fs_n[i]] = k; fs_n[i]++; end
      prev_hs[i] = hs_o[i];
      prev_vs[i] = vs_o[i];
    end
  endtask

  // Called at a falling edge while rst is high: releases reset and treats this cycle as k=0.
  task automatic begin_run();
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      hs_nf[i] = 0; hs_nr[i] = 0; vs_nf[i] = 0; vs_nr[i] = 0; fs_n[i] = 0;
      prev_hs[i] = 1'b1; prev_vs[i] = 1'b1;
    end
    #1;
    compare_model();
    log_events();
    drive_colors();
  endtask

  task automatic step();
    @(negedge vgaclk);
    k++;
    compare_model();
    log_events();
    drive_colors();
  endtask

  task automatic test_reset();
    mism = 0;
    mode = 0;
    for (int i = 0; i < N; i++) color_i[i] = 8'hFF;
    repeat (3) @(posedge vgaclk);
    #5;
    for (int i = 0; i < N; i++) begin
      tests++;
      if ({row_o[i], col_o[i], act_o[i], ls_o[i], fs_o[i], red_o[i], grn_o[i], blu_o[i], hs_o[i], vs_o[i]}
          !== {9'd0, 10'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL reset_values inst%0d: row=%0d col=%0d act=%b ls=%b fs=%b rgb=%b%b%b hs=%b vs=%b, required all zero with syncs 1",
                 i, row_o[i], col_o[i], act_o[i], ls_o[i], fs_o[i], red_o[i], grn_o[i], blu_o[i], hs_o[i], vs_o[i]);
      end
    end
    @(negedge vgaclk);
    begin_run();
    for (int i = 0; i < N; i++) begin
      tests++;
      if (col_o[i] !== 10'd0) begin
        fails++;
        $display("FAIL release_column inst%0d: got %0d, required 0", i, col_o[i]);
      end
    end
    step();
    for (int i = 0; i < N; i++) begin
      tests++;
      if (col_o[i] !== 10'd1) begin
        fails++;
        $display("FAIL first_edge_column inst%0d: got %0d, required 1", i, col_o[i]);
      end
    end
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL model_reset: %0d bad cycles (required 0), first %s", mism, first_msg); end
  endtask

  task automatic test_const_color();
    int a5_cnt, other_cnt;
    mism = 0;
    mode = 0;
    a5_cnt = 0;
    other_cnt = 0;
    while (k < 2600) begin
      step();
      // Lines 1 and 2 of the full-size raster, shifted by the pin latency.
      if (k >= 800 + lat[0] + 1 && k < 2400 + lat[0] + 1) begin
        if ({red_o[0], grn_o[0], blu_o[0]} === {3'b101, 3'b001, 2'b01}) a5_cnt++;
        else if ({red_o[0], grn_o[0], blu_o[0]} !== 8'h00) other_cnt++;
      end
    end
    tests++;
    if (a5_cnt !== 1280) begin fails++; $display("FAIL const_pixels: %0d A5 pixels over 2 lines, required 1280", a5_cnt); end
    tests++;
    if (other_cnt !== 0) begin fails++; $display("FAIL const_blank: %0d non-blank off-pixels, required 0", other_cnt); end
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL model_const: %0d bad cycles (required 0), first %s", mism, first_msg); end
  endtask

  task automatic test_hsync();
    for (int i = 0; i < 2; i++) begin
      int e_first;
      e_first = ha[i] + hfp[i] + lat[i] + 1;
      tests++;
      if (hs_nf[i] < 2 || hs_nr[i] < 1) begin
        fails++;
        $display("FAIL hsync_seen inst%0d: %0d falls %0d rises, required at least 2 and 1", i, hs_nf[i], hs_nr[i]);
      end else begin
        if (hs_fall[i][0] !== e_first) begin
          fails++;
          $display("FAIL hsync_first_fall inst%0d: at k=%0d, required %0d", i, hs_fall[i][0], e_first);
        end
        tests++;
        if (hs_rise[i][0] - hs_fall[i][0] !== hsw[i]) begin
          fails++;
          $display("FAIL hsync_width inst%0d: %0d cycles, required %0d", i, hs_rise[i][0] - hs_fall[i][0], hsw[i]);
        end
        tests++;
        if (hs_fall[i][1] - hs_fall[i][0] !== htot(i)) begin
          fails++;
          $display("FAIL hsync_period inst%0d: %0d cycles, required %0d", i, hs_fall[i][1] - hs_fall[i][0], htot(i));
        end
      end
    end
  endtask

  task automatic test_column_pixels();
    int k0, edge_bad, edge_ok;
    mism = 0;
    mode = 1;
    k0 = k + 1;
    edge_bad = 0;
    edge_ok = 0;
    repeat (1400) begin
      step();
      for (int i = 1; i < N; i++) begin
        int j;
        logic [7:0] pins;
        j = k - lat[i] - 1;
        pins = {red_o[i], grn_o[i], blu_o[i]};
        if (j >= k0 && vc(i, j) < va[i]) begin
          if (hc(i, j) == ha[i] - 1) begin
            if (pins === 8'(ha[i] - 1)) edge_ok++; else edge_bad++;
          end
          if (hc(i, j) == 1) begin
            if (pins === 8'd1) edge_ok++; else edge_bad++;
          end
          if (hc(i, j) == ha[i] && pins !== 8'h00) edge_bad++;
        end
      end
    end
    tests++;
    if (edge_bad !== 0) begin fails++; $display("FAIL column_edges: %0d wrong edge pixels, required 0", edge_bad); end
    tests++;
    if (edge_ok < 20) begin fails++; $display("FAIL column_edge_count: %0d edge pixels matched, required at least 20", edge_ok); end
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL model_column: %0d bad cycles (required 0), first %s", mism, first_msg); end
  endtask

  task automatic test_random();
    mism = 0;
    mode = 2;
    repeat (1300) step();
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL model_random: %0d bad cycles (required 0), first %s", mism, first_msg); end
  endtask

  task automatic test_vsync_frames();
    for (int i = 1; i < N; i++) begin
      int e_first;
      e_first = (va[i] + vfp[i]) * htot(i) + lat[i] + 1;
      tests++;
      if (vs_nf[i] < 2 || vs_nr[i] < 1 || fs_n[i] < 2) begin
        fails++;
        $display("FAIL vsync_seen inst%0d: %0d falls %0d rises %0d frame pulses, required 2/1/2", i, vs_nf[i], vs_nr[i], fs_n[i]);
      end else begin
        if (vs_fall[i][0] !== e_first) begin
          fails++;
          $display("FAIL vsync_first_fall inst%0d: at k=%0d, required %0d", i, vs_fall[i][0], e_first);
        end
        tests++;
        if (vs_rise[i][0] - vs_fall[i][0] !== vsw[i] * htot(i)) begin
          fails++;
          $display("FAIL vsync_width inst%0d: %0d cycles, required %0d", i, vs_rise[i][0] - vs_fall[i][0], vsw[i] * htot(i));
        end
        tests++;
        if (vs_fall[i][1] - vs_fall[i][0] !== vtot(i) * htot(i)) begin
          fails++;
          $display("FAIL vsync_period inst%0d: %0d cycles, required %0d", i, vs_fall[i][1] - vs_fall[i][0], vtot(i) * htot(i));
        end
        tests++;
        if (fs_k[i][0] !== vtot(i) * htot(i) || fs_k[i][1] - fs_k[i][0] !== vtot(i) * htot(i)) begin
          fails++;
          $display("FAIL frame_start inst%0d: pulses at k=%0d and %0d, required %0d and %0d", i, fs_k[i][0], fs_k[i][1],
                   vtot(i) * htot(i), 2 * vtot(i) * htot(i));
        end
      end
    end
  endtask

  task automatic test_vblank();
    tests++;
    if (vb_bad !== 0) begin fails++; $display("FAIL vblank_row_active: %0d cycles with row/active set, required 0", vb_bad); end
    tests++;
    if (vb_cycles < 2 * (vtot(1) - va[1]) * htot(1)) begin
      fails++;
      $display("FAIL vblank_coverage: %0d blank cycles seen, required at least %0d", vb_cycles, 2 * (vtot(1) - va[1]) * htot(1));
    end
    tests++;
    if (vb_colmax !== htot(1) - 1) begin fails++; $display("FAIL vblank_column: max column %0d, required %0d", vb_colmax, htot(1) - 1); end
  endtask

  task automatic test_mid_reset();
    int guard;
    mism = 0;
    guard = 0;
    // Stop inside line 5 while the shrunken raster's hsync pin is asserted.
    while (!(vc(1, k) == 5 && hc(1, k) == 47) && guard < 3000) begin
      step();
      guard++;
    end
    tests++;
    if (guard >= 3000) begin
      fails++;
      $display("FAIL mid_reset_reach: target position not reached in %0d cycles, required < 3000", guard);
    end
    tests++;
    if (hs_o[1] !== 1'b0) begin fails++; $display("FAIL mid_reset_pre_hsync: got %b, required 0", hs_o[1]); end
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      tests++;
      if ({row_o[i], col_o[i], act_o[i], ls_o[i], fs_o[i], red_o[i], grn_o[i], blu_o[i], hs_o[i], vs_o[i]}
          !== {9'd0, 10'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL mid_reset_values inst%0d: row=%0d col=%0d act=%b ls=%b fs=%b rgb=%b%b%b hs=%b vs=%b, required all zero with syncs 1",
                 i, row_o[i], col_o[i], act_o[i], ls_o[i], fs_o[i], red_o[i], grn_o[i], blu_o[i], hs_o[i], vs_o[i]);
      end
    end
    repeat (3) @(posedge vgaclk);
    @(negedge vgaclk);
    begin_run();
    tests++;
    if (col_o[1] !== 10'd0) begin fails++; $display("FAIL mid_reset_release_column: got %0d, required 0", col_o[1]); end
    repeat (900) step();
    tests++;
    if (vs_nf[1] < 1 || vs_fall[1][0] !== (va[1] + vfp[1]) * htot(1) + lat[1] + 1) begin
      fails++;
      $display("FAIL mid_reset_vsync: %0d falls, first at k=%0d, required k=%0d", vs_nf[1], vs_fall[1][0],
               (va[1] + vfp[1]) * htot(1) + lat[1] + 1);
    end
    tests++;
    if (hs_nf[0] < 1 || hs_fall[0][0] !== ha[0] + hfp[0] + lat[0] + 1) begin
      fails++;
      $display("FAIL mid_reset_hsync: %0d falls, first at k=%0d, required k=%0d", hs_nf[0], hs_fall[0][0], ha[0] + hfp[0] + lat[0] + 1);
    end
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL model_mid_reset: %0d bad cycles (required 0), first %s", mism, first_msg); end
  endtask

  initial begin
    vb_cycles = 0;
    vb_bad    = 0;
    vb_colmax = 0;
    first_msg = "";
    test_reset();
    test_const_color();
    test_hsync();
    test_column_pixels();
    test_random();
    test_vsync_frames();
    test_vblank();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
